resp_misr_compactor: RTL and testbench



---
 rtl/resp_misr_compactor.sv | 110 +++++++++++
 tb/tb_resp_misr_compactor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/resp_misr_compactor.sv
// Response-capture stage: compacts 14-bit response vectors into a Galois MISR and checks the result against a golden signature.
// Optional build macro RESP_XMASK_EN adds an xmask input that forces masked response bits to zero before compaction.
module resp_misr_compactor #(
  parameter int                RESP_W = 14,
  parameter int                SIG_W  = 16,
  parameter logic [SIG_W-1:0]  POLY   = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED   = 16'h0000,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [SIG_W-1:0]  golden,
`ifdef RESP_XMASK_EN
  input  logic [RESP_W-1:0] xmask,
`endif
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_data,
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  vec_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   num_vec_q;
  logic [SIG_W-1:0]   golden_q;
  logic [RESP_W-1:0]  resp_eff;
  logic [SIG_W-1:0]   sig_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;

`ifdef RESP_XMASK_EN
  logic [RESP_W-1:0]  xmask_q;
  assign resp_eff = resp_data & ~xmask_q;
`else
  assign resp_eff = resp_data;
`endif

  // Handshake qualifiers decode the state register only, never resp_valid.
  assign resp_ready = (state == RUN);
  assign busy       = (state == RUN) || (state == CHECK);
  assign done       = (state == DONE);
  assign accept     = resp_valid && resp_ready;
  assign cnt_inc    = vec_count + CNT_W'(1);

  always_comb begin
    sig_next = {signature[SIG_W-2:0], 1'b0};
    if (signature[SIG_W-1]) begin
      sig_next = sig_next ^ POLY;
    end
    sig_next = sig_next ^ SIG_W'(resp_eff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      signature <= SEED;
      vec_count <= '0;
      pass      <= 1'b0;
      num_vec_q <= '0;
      golden_q  <= '0;
`ifdef RESP_XMASK_EN
      xmask_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            signature <= SEED;
            vec_count <= '0;
            pass      <= 1'b0;
            num_vec_q <= num_vec;
            golden_q  <= golden;
`ifdef RESP_XMASK_EN
            xmask_q   <= xmask;
`endif
            state     <= (num_vec != '0) ? RUN : CHECK;
          end
        end
        RUN: begin
          if (accept) begin
            signature <= sig_next;
            vec_count <= cnt_inc;
            // Compare against the incremented count so the last beat never wraps the counter.
            if (cnt_inc == num_vec_q) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          pass  <= (signature == golden_q);
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_resp_misr_compactor.sv
// Self-checking bench for resp_misr_compactor: vector table, randomized runs and multi-cycle corner sequences.
module tb_resp_misr_compactor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_vec;
  logic [15:0] golden;
  logic        resp_valid;
  logic [13:0] resp_data;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] vec_count;
  logic [13:0] xm = '0;
`ifdef RESP_XMASK_EN
  logic [13:0] xmask;
  assign xmask = xm;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  resp_misr_compactor #(
    .RESP_W (14),
    .SIG_W  (16),
    .POLY   (16'h1021),
    .SEED   (16'h0000),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_vec    (num_vec),
    .golden     (golden),
`ifdef RESP_XMASK_EN
    .xmask      (xmask),
`endif
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .vec_count  (vec_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          nv;
    logic [15:0] gold;
    logic [13:0] data [4];
    logic [15:0] exp_sig;
    logic        exp_pass;
  } vec_t;

  logic [13:0] vecs [$];

  // Signature as polynomial arithmetic: multiply by x, reduce modulo x^16+POLY, add the vector.
  function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [13:0] d);
    int unsigned v;
    v = s * 2;
    if (v >= 32'h10000) v = v ^ 32'h11021;
    v = v ^ 32'(d & ~xm);
    return v[15:0];
  endfunction

  function automatic logic [15:0] ref_sig();
    logic [15:0] s = 16'h0000;
    foreach (vecs[i]) s = ref_step(s, vecs[i]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, " signature"}, 32'(signature), 32'h0000);
    chk({name, " vec_count"}, 32'(vec_count), 32'h0);
    chk({name, " ready"},     32'(resp_ready), 32'h0);
    chk({name, " busy"},      32'(busy), 32'h0);
    chk({name, " done"},      32'(done), 32'h0);
    chk({name, " pass"},      32'(pass), 32'h0);
  endtask

  task automatic do_start(input int nv, input logic [15:0] gold);
    num_vec = 16'(nv);
    golden  = gold;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    num_vec = 16'($urandom);
    golden  = 16'($urandom);
  endtask

  // Drives the queued vectors through a full run and checks every step against the model.
  task automatic run_vecs(input logic [15:0] gold, input bit gaps, output logic [15:0] s);
    s = 16'h0000;
    do_start(vecs.size(), gold);
    foreach (vecs[i]) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        resp_valid = 1'b0;
        resp_data  = 14'($urandom);
        tick();
        chk("gap vec_count", 32'(vec_count), 32'(i));
      end
      resp_valid = 1'b1;
      resp_data  = vecs[i];
      tick();
      s = ref_step(s, vecs[i]);
      chk("beat signature", 32'(signature), 32'(s));
      chk("beat vec_count", 32'(vec_count), 32'(i + 1));
    end
    resp_valid = 1'b0;
    resp_data  = 14'($urandom);
    chk("check-state done", 32'(done), 32'h0);
    chk("check-state busy", 32'(busy), 32'h1);
    chk("check-state ready", 32'(resp_ready), 32'h0);
    tick();
    chk("done high", 32'(done), 32'h1);
    chk("done busy low", 32'(busy), 32'h0);
    chk("model pass", 32'(pass), 32'(s == gold));
  endtask

  vec_t        tbl [6];
  logic [15:0] s;
  logic [15:0] g;

  initial begin
    tbl[0] = '{nv: 1, gold: 16'h3FFF, data: '{14'h3FFF, 0, 0, 0},          exp_sig: 16'h3FFF, exp_pass: 1'b1};
    tbl[1] = '{nv: 2, gold: 16'h4000, data: '{14'h2000, 0, 0, 0},          exp_sig: 16'h4000, exp_pass: 1'b1};
    tbl[2] = '{nv: 3, gold: 16'h8000, data: '{14'h2000, 0, 0, 0},          exp_sig: 16'h8000, exp_pass: 1'b1};
    tbl[3] = '{nv: 4, gold: 16'h1021, data: '{14'h2000, 0, 0, 0},          exp_sig: 16'h1021, exp_pass: 1'b1};
    tbl[4] = '{nv: 2, gold: 16'h0005, data: '{14'h0001, 14'h0002, 0, 0},   exp_sig: 16'h0000, exp_pass: 1'b0};
    tbl[5] = '{nv: 0, gold: 16'h1234, data: '{0, 0, 0, 0},                 exp_sig: 16'h0000, exp_pass: 1'b0};

    rst_n = 1'b0; start = 1'b0; num_vec = '0; golden = '0;
    resp_valid = 1'b0; resp_data = '0;
    tick(); tick();
    chk_reset_vals("in reset");
    rst_n = 1'b1;
    tick();
    chk_reset_vals("idle");

    // resp_valid in IDLE is ignored.
    resp_valid = 1'b1; resp_data = 14'h1555;
    tick(); tick();
    chk("idle valid vec_count", 32'(vec_count), 32'h0);
    chk("idle valid signature", 32'(signature), 32'h0);
    resp_valid = 1'b0;

    foreach (tbl[t]) begin
      vecs.delete();
      for (int unsigned i = 0; i < 32'(tbl[t].nv); i++) vecs.push_back(tbl[t].data[i]);
      run_vecs(tbl[t].gold, 1'b0, s);
      chk($sformatf("table%0d signature", t), 32'(signature), 32'(tbl[t].exp_sig));
      chk($sformatf("table%0d pass", t),      32'(pass), 32'(tbl[t].exp_pass));
    end

    // Zero-length run against the seed.
    vecs.delete();
    run_vecs(16'h0000, 1'b0, s);
    chk("zero-length pass", 32'(pass), 32'h1);
    chk("zero-length count", 32'(vec_count), 32'h0);

    // DONE holds while resp_valid toggles.
    resp_valid = 1'b1; resp_data = 14'h2AAA;
    tick(); tick();
    resp_valid = 1'b0;
    chk("done hold", 32'(done), 32'h1);
    chk("done hold pass", 32'(pass), 32'h1);
    chk("done hold signature", 32'(signature), 32'h0);

    // Randomized runs, half with matching golden.
    for (int r = 0; r < 24; r++) begin
      vecs.delete();
      for (int unsigned i = 0; i < $urandom_range(1, 12); i++) vecs.push_back(14'($urandom));
      g = ref_sig();
      if ($urandom_range(0, 1) == 1) g = g ^ 16'(1 << $urandom_range(0, 15));
      run_vecs(g, 1'b1, s);
      chk($sformatf("random%0d signature", r), 32'(signature), 32'(ref_sig()));
    end

    // Backpressure: valid held for 5 cycles, only 2 beats accepted.
    do_start(2, 16'hABCD);
    s = 16'h0000;
    for (int unsigned i = 0; i < 5; i++) begin
      resp_valid = 1'b1;
      resp_data  = 14'($urandom);
      if (i < 2) s = ref_step(s, resp_data);
      tick();
    end
    resp_valid = 1'b0;
    chk("overrun vec_count", 32'(vec_count), 32'h2);
    chk("overrun ready", 32'(resp_ready), 32'h0);
    chk("overrun signature", 32'(signature), 32'(s));
    chk("overrun done", 32'(done), 32'h1);
    chk("overrun pass", 32'(pass), 32'(s == 16'hABCD));

    // start during RUN is ignored.
    vecs.delete();
    for (int unsigned i = 0; i < 4; i++) vecs.push_back(14'($urandom));
    g = ref_sig();
    do_start(4, g);
    s = 16'h0000;
    for (int unsigned i = 0; i < 2; i++) begin
      resp_valid = 1'b1; resp_data = vecs[i];
      tick();
      s = ref_step(s, vecs[i]);
    end
    resp_valid = 1'b0;
    do_start(1, 16'h0000);
    chk("ignored start count", 32'(vec_count), 32'h2);
    chk("ignored start signature", 32'(signature), 32'(s));
    chk("ignored start busy", 32'(busy), 32'h1);
    for (int unsigned i = 2; i < 4; i++) begin
      resp_valid = 1'b1; resp_data = vecs[i];
      tick();
    end
    resp_valid = 1'b0;
    tick();
    chk("ignored start final done", 32'(done), 32'h1);
    chk("ignored start final sig", 32'(signature), 32'(g));
    chk("ignored start final pass", 32'(pass), 32'h1);

    // Reset after 3 of 8 beats.
    do_start(8, 16'h0000);
    for (int unsigned i = 0; i < 3; i++) begin
      resp_valid = 1'b1; resp_data = 14'($urandom) | 14'h1;
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk_reset_vals("mid-run reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset_vals("after reset");
    resp_valid = 1'b0;

`ifdef RESP_XMASK_EN
    xm = 14'h3FFF;
    vecs.delete();
    for (int unsigned i = 0; i < 5; i++) vecs.push_back(14'($urandom));
    run_vecs(16'h0000, 1'b0, s);
    chk("xmask signature", 32'(signature), 32'h0000);
    chk("xmask pass", 32'(pass), 32'h1);
    xm = 14'h00FF;
    vecs.delete();
    for (int unsigned i = 0; i < 6; i++) vecs.push_back(14'($urandom));
    run_vecs(ref_sig(), 1'b0, s);
    chk("partial xmask pass", 32'(pass), 32'h1);
    xm = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
